// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, the fetch FSM state encoding
// and the NOP word used to clear the IF/ID register.
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      FS_IDLE  = 2'd0,
      FS_FETCH = 2'd1,
      FS_DRAIN = 2'd2,
      FS_SKID  = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC logic: sequential PC, jump/branch targets and the
// redirect decision taken from the instruction sitting in IF/ID.
module next_pc_calc
   import cpu_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] pc_plus4,
   input  logic [25:0] instr_low,
   input  logic        instr_valid,
   input  logic        stall,
   input  logic        jump,
   input  logic        branch,
   input  logic        zero,
   output logic [31:0] seq_pc,
   output logic [31:0] target,
   output logic        redirect
);

   logic [31:0] branch_off;
   logic [31:0] branch_tgt;
   logic [31:0] jump_tgt;

   assign seq_pc     = pc + 32'd4;
   assign branch_off = {{14{instr_low[15]}}, instr_low[15:0], 2'b00};
   assign branch_tgt = pc_plus4 + branch_off;
   assign jump_tgt   = {pc_plus4[31:28], instr_low, 2'b00};
   assign target     = jump ? jump_tgt : branch_tgt;

   // instr_valid gates first so decoder x's on a bubble never leak into redirect
   assign redirect   = instr_valid && !stall && (jump || (branch && zero));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, instruction-memory request FSM, one-entry
// skid buffer and the IF/ID register feeding the control decoder.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        flush,
   input  logic        Jump,
   input  logic        Branch,
   input  logic        Zero,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   output logic [1:0]  fsm_state
);

   localparam logic [1:0] IDLE  = FS_IDLE;
   localparam logic [1:0] FETCH = FS_FETCH;
   localparam logic [1:0] DRAIN = FS_DRAIN;
   localparam logic [1:0] SKID  = FS_SKID;

   logic [1:0]  state;
   logic [31:0] pc;
   logic [31:0] req_addr;
   logic [31:0] skid_word;
   logic [31:0] skid_pc4;
   logic [31:0] seq_pc;
   logic [31:0] target;
   logic        redirect;
   logic        can_load;
   logic        load_mem;
   logic        load_skid;

   next_pc_calc u_next_pc (
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .instr_low   (instr[25:0]),
      .instr_valid (instr_valid),
      .stall       (stall),
      .jump        (Jump),
      .branch      (Branch),
      .zero        (Zero),
      .seq_pc      (seq_pc),
      .target      (target),
      .redirect    (redirect)
   );

   // Memory handshake: a word transfers on any edge where imem_req && imem_ready;
   // while imem_req && !imem_ready the address is held and may not be withdrawn.
   assign imem_req  = (state == FETCH) || (state == DRAIN);
   assign imem_addr = req_addr;
   assign opcode    = instr[31:26];
   assign fsm_state = state;

   assign can_load  = !stall || !instr_valid;
   assign load_mem  = (state == FETCH) && imem_ready && can_load;
   assign load_skid = (state == SKID) && can_load;

   // pc only advances once a word actually reaches IF/ID, so a flushed word is refetched
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         req_addr  <= RESET_PC;
         skid_word <= NOP_INSTR;
         skid_pc4  <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               state    <= FETCH;
               req_addr <= pc;
            end
            FETCH: begin
               if (redirect) begin
                  pc <= target;
                  if (imem_ready) req_addr <= target;
                  else            state    <= DRAIN;
               end else if (imem_ready && !flush) begin
                  if (can_load) begin
                     pc       <= seq_pc;
                     req_addr <= seq_pc;
                  end else begin
                     skid_word <= imem_rdata;
                     skid_pc4  <= seq_pc;
                     state     <= SKID;
                  end
               end
            end
            SKID: begin
               if (redirect) begin
                  pc       <= target;
                  req_addr <= target;
                  state    <= FETCH;
               end else if (flush) begin
                  state <= FETCH;
               end else if (can_load) begin
                  pc       <= seq_pc;
                  req_addr <= seq_pc;
                  state    <= FETCH;
               end
            end
            DRAIN: begin
               if (redirect) pc <= target;
               if (imem_ready) begin
                  req_addr <= redirect ? target : pc;
                  state    <= FETCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr       <= NOP_INSTR;
         pc_plus4    <= 32'h0;
         instr_valid <= 1'b0;
      end else if (redirect || flush) begin
         instr_valid <= 1'b0;
      end else if (stall && instr_valid) begin
         instr_valid <= 1'b1;
      end else if (load_mem) begin
         instr       <= imem_rdata;
         pc_plus4    <= seq_pc;
         instr_valid <= 1'b1;
      end else if (load_skid) begin
         instr       <= skid_word;
         pc_plus4    <= skid_pc4;
         instr_valid <= 1'b1;
      end else begin
         instr_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed phases (sequential fetch, jump, beq, skid,
// drain, flush, reset mid-drain) plus a program-order model checked every cycle.
module tb_fetch_stage;
   import cpu_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam logic [31:0] J_WORD = 32'h0804_0010;
   localparam logic [31:0] BEQ_WORD = 32'h1000_FFFE;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        flush;
   logic        Jump;
   logic        Branch;
   logic        Zero;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic [1:0]  fsm_state;

   int checks = 0;
   int errors = 0;

   logic [31:0] ov_a0, ov_d0, ov_a1, ov_d1;

   fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .flush       (flush),
      .Jump        (Jump),
      .Branch      (Branch),
      .Zero        (Zero),
      .instr       (instr),
      .opcode      (opcode),
      .pc_plus4    (pc_plus4),
      .instr_valid (instr_valid),
      .fsm_state   (fsm_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // memory returns the address as data, except at two patchable addresses
   assign imem_rdata = (imem_addr == ov_a0) ? ov_d0 :
                       (imem_addr == ov_a1) ? ov_d1 : imem_addr;
   // decoder stand-in
   assign Jump   = (opcode == OP_J);
   assign Branch = (opcode == OP_BEQ);

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == ov_a0) return ov_d0;
      if (a == ov_a1) return ov_d1;
      return a;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // program-order model: every instruction leaving IF/ID must be the next one
   // the program would execute, with pc_plus4 = its address + 4
   logic [31:0] exp_pc;
   logic        prev_req, prev_ready;
   logic [31:0] prev_addr;

   always @(negedge clk) begin
      logic [31:0] w, nxt, imm;
      #4;
      if (rst) begin
         exp_pc   = RST_PC;
         prev_req = 1'b0;
      end else begin
         if (prev_req && !prev_ready) begin
            check("hold_req", {31'b0, imem_req}, 32'd1);
            check("hold_addr", imem_addr, prev_addr);
         end
         if (instr_valid && (!stall || flush)) begin
            w = mem_word(exp_pc);
            check("model_instr", instr, w);
            check("model_pc4", pc_plus4, exp_pc + 32'd4);
            nxt = exp_pc + 32'd4;
            if (!stall) begin
               imm = {{16{w[15]}}, w[15:0]};
               if (w[31:26] == OP_J)
                  nxt = (nxt & 32'hF000_0000) | ({6'b0, w[25:0]} << 2);
               else if (w[31:26] == OP_BEQ && Zero)
                  nxt = nxt + (imm << 2);
            end
            exp_pc = nxt;
         end
         prev_req   = imem_req;
         prev_ready = imem_ready;
         prev_addr  = imem_addr;
      end
   end

   initial begin
      rst = 1'b1; imem_ready = 1'b1; stall = 1'b0; flush = 1'b0; Zero = 1'b0;
      ov_a0 = 32'h0040_0010; ov_d0 = J_WORD;
      ov_a1 = 32'hFFFF_FFFC; ov_d1 = 32'hFFFF_FFFC;

      // phase 1: reset values, sequential stream, jump
      step(); step();
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_addr", imem_addr, RST_PC);
      check("rst_instr", instr, 32'h0);
      check("rst_opcode", {26'b0, opcode}, 32'h0);
      check("rst_pc4", pc_plus4, 32'h0);
      check("rst_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_state", {30'b0, fsm_state}, 32'(FS_IDLE));
      rst = 1'b0;
      step();  // E1
      check("p1e1_addr", imem_addr, 32'h0040_0000);
      check("p1e1_req", {31'b0, imem_req}, 32'd1);
      check("p1e1_valid", {31'b0, instr_valid}, 32'd0);
      step();  // E2
      check("p1e2_valid", {31'b0, instr_valid}, 32'd1);
      check("p1e2_instr", instr, 32'h0040_0000);
      check("p1e2_pc4", pc_plus4, 32'h0040_0004);
      check("p1e2_addr", imem_addr, 32'h0040_0004);
      step();  // E3
      check("p1e3_addr", imem_addr, 32'h0040_0008);
      check("p1e3_pc4", pc_plus4, 32'h0040_0008);
      step(); step(); step();  // E6
      check("p1e6_instr", instr, J_WORD);
      check("p1e6_opcode", {26'b0, opcode}, 32'h2);
      check("p1e6_addr", imem_addr, 32'h0040_0014);
      step();  // E7
      check("jmp_addr", imem_addr, 32'h0010_0040);
      check("jmp_bubble", {31'b0, instr_valid}, 32'd0);
      step();  // E8
      check("jmp_valid", {31'b0, instr_valid}, 32'd1);
      check("jmp_instr", instr, 32'h0010_0040);
      check("jmp_pc4", pc_plus4, 32'h0010_0044);
      repeat (3) step();

      // phase 2: beq taken then not taken, skid, drain, flush
      rst = 1'b1; Zero = 1'b1;
      ov_a0 = 32'h0040_000C; ov_d0 = BEQ_WORD;
      ov_a1 = 32'h0040_0024; ov_d1 = J_WORD;
      step(); step();
      rst = 1'b0;
      repeat (5) step();  // E5
      check("beq_instr", instr, BEQ_WORD);
      check("beq_pc4", pc_plus4, 32'h0040_0010);
      step();  // E6
      check("beq_tgt", imem_addr, 32'h0040_0008);
      check("beq_bubble", {31'b0, instr_valid}, 32'd0);
      Zero = 1'b0;
      step();  // E7
      check("beq_e7_instr", instr, 32'h0040_0008);
      check("beq_e7_pc4", pc_plus4, 32'h0040_000C);
      step();  // E8
      check("beq2_pc4", pc_plus4, 32'h0040_0010);
      check("beq2_opcode", {26'b0, opcode}, 32'h4);
      step();  // E9
      check("nt_instr", instr, 32'h0040_0010);
      check("nt_addr", imem_addr, 32'h0040_0014);
      step();  // E10
      stall = 1'b1;
      step();  // E11
      check("skid_req", {31'b0, imem_req}, 32'd0);
      check("skid_instr", instr, 32'h0040_0014);
      check("skid_state", {30'b0, fsm_state}, 32'(FS_SKID));
      step(); step();  // E13
      check("skid_hold", instr, 32'h0040_0014);
      check("skid_req2", {31'b0, imem_req}, 32'd0);
      stall = 1'b0;
      step();  // E14
      check("unskid_instr", instr, 32'h0040_0018);
      check("unskid_addr", imem_addr, 32'h0040_001C);
      check("unskid_req", {31'b0, imem_req}, 32'd1);
      step(); step(); step();  // E17
      check("j2_instr", instr, J_WORD);
      imem_ready = 1'b0;
      step();  // E18
      check("drain_state", {30'b0, fsm_state}, 32'(FS_DRAIN));
      check("drain_req", {31'b0, imem_req}, 32'd1);
      check("drain_addr", imem_addr, 32'h0040_0028);
      check("drain_valid", {31'b0, instr_valid}, 32'd0);
      step(); step(); step();  // E21
      check("drain_hold", imem_addr, 32'h0040_0028);
      imem_ready = 1'b1;
      step();  // E22
      check("drain_tgt", imem_addr, 32'h0010_0040);
      check("drain_bubble", {31'b0, instr_valid}, 32'd0);
      check("drain_exit", {30'b0, fsm_state}, 32'(FS_FETCH));
      step();  // E23
      check("drain_instr", instr, 32'h0010_0040);
      flush = 1'b1;
      step();  // E24
      flush = 1'b0;
      check("flush_valid", {31'b0, instr_valid}, 32'd0);
      check("flush_addr", imem_addr, 32'h0010_0044);
      step();  // E25
      check("flush_next", instr, 32'h0010_0044);
      check("flush_nvalid", {31'b0, instr_valid}, 32'd1);
      repeat (2) step();

      // phase 3: reset asserted while draining
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      repeat (11) step();  // E11
      check("p3_j", instr, J_WORD);
      imem_ready = 1'b0;
      step();  // E12
      check("p3_drain", {30'b0, fsm_state}, 32'(FS_DRAIN));
      #2 rst = 1'b1;
      #1;
      check("arst_req", {31'b0, imem_req}, 32'd0);
      check("arst_addr", imem_addr, RST_PC);
      check("arst_instr", instr, 32'h0);
      check("arst_opcode", {26'b0, opcode}, 32'h0);
      check("arst_pc4", pc_plus4, 32'h0);
      check("arst_valid", {31'b0, instr_valid}, 32'd0);
      check("arst_state", {30'b0, fsm_state}, 32'(FS_IDLE));
      imem_ready = 1'b1;
      step();
      rst = 1'b0;
      step();  // E1
      check("p3e1_addr", imem_addr, RST_PC);
      step();  // E2
      check("p3e2_instr", instr, RST_PC);
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
